// File: rtl/serial_full_adder.sv
// rtl/serial_full_adder.sv - bit-serial WIDTH-bit adder (one full-adder cell + carry register) with valid/ready handshakes
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice (>= 1 since WIDTH >= 2).
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  // Holds the WIDTH-1 low sum bits produced so far; the last bit joins them on the final edge.
  logic [WIDTH-2:0]   res_sr_q, res_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               out_valid_q, out_valid_d;

  logic               fa_s;
  logic               fa_c;
  logic [WIDTH-1:0]   res_shift;
  logic               last_bit;

  // Single full-adder cell working on the current LSBs and the stored carry.
  always_comb begin
    fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    fa_c = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
  end

  // New sum bit enters at the MSB; the concatenation keeps the slice legal for WIDTH == 2.
  always_comb begin
    res_shift = {fa_s, res_sr_q};
    last_bit  = (cnt_q == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: in_valid only matters in IDLE, out_ready only in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded straight from state.
  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
  end

  // Datapath next-state: operand load, serial add, result capture and out_valid.
  always_comb begin
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    res_sr_d    = res_sr_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_c;
        res_sr_d = res_shift[WIDTH-1:1];
        if (last_bit) begin
          // Counter parks at WIDTH-1 instead of wrapping.
          sum_d       = res_shift;
          cout_d      = fa_c;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_sr_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      res_sr_q    <= res_sr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule
